// File: rtl/ad_uart_tx.sv
// Packetising UART transmitter: snapshots eight 14-bit ADC channels on request and
// sends a 19-byte 8N1 frame (sync word, channel data, modulo-256 checksum).
module ad_uart_tx #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snap,
  input  logic [13:0] ad_dat0,
  input  logic [13:0] ad_dat1,
  input  logic [13:0] ad_dat2,
  input  logic [13:0] ad_dat3,
  input  logic [13:0] ad_dat4,
  input  logic [13:0] ad_dat5,
  input  logic [13:0] ad_dat6,
  input  logic [13:0] ad_dat7,
  output logic        txd,
  output logic        busy,
  output logic        pkt_done,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned NCH       = 8;
  localparam int unsigned DAT_W     = 14;
  localparam int unsigned IDX_W     = 5;
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(18);
  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [IDX_W-1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]                  byte_q, byte_d;
  logic [7:0]                  csum_q, csum_d;
  logic [NCH-1:0][DAT_W-1:0]   dat_q, dat_d;
  logic                        txd_q, txd_d;
  logic                        busy_q, busy_d;
  logic                        pkt_done_q, pkt_done_d;
  logic [7:0]                  drop_cnt_q, drop_cnt_d;

  logic [3:0]                  rel_c;
  logic [DAT_W-1:0]            next_dat_c;
  logic [7:0]                  next_byte_c;

  // Byte that follows the current one: sync, channel hi/lo halves, then checksum.
  always_comb begin
    rel_c      = 4'(byte_idx_q - IDX_W'(1));
    next_dat_c = dat_q[rel_c[3:1]];
    if (byte_idx_q == IDX_W'(0)) begin
      next_byte_c = SYNC1;
    end else if (byte_idx_q == IDX_W'(17)) begin
      next_byte_c = csum_q;
    end else if (rel_c[0]) begin
      next_byte_c = next_dat_c[7:0];
    end else begin
      next_byte_c = {2'b00, next_dat_c[13:8]};
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    byte_d     = byte_q;
    csum_d     = csum_q;
    dat_d      = dat_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    pkt_done_d = 1'b0;
    drop_cnt_d = drop_cnt_q;

    if (snap && busy_q && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (snap) begin
          dat_d      = {ad_dat7, ad_dat6, ad_dat5, ad_dat4,
                        ad_dat3, ad_dat2, ad_dat1, ad_dat0};
          state_d    = START;
          busy_d     = 1'b1;
          txd_d      = 1'b0;
          bit_cnt_d  = DIV_M1;
          byte_idx_d = '0;
          byte_d     = SYNC0;
          csum_d     = '0;
        end
      end
      START: begin
        if (bit_cnt_q == '0) begin
          state_d   = DATA;
          bit_cnt_d = DIV_M1;
          bit_idx_d = '0;
          txd_d     = byte_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt_q == '0) begin
          bit_cnt_d = DIV_M1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = byte_q[3'(bit_idx_q + 3'd1)];
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_cnt_q == '0) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            pkt_done_d = 1'b1;
            byte_idx_d = '0;
          end else begin
            // Back-to-back start bit; channel bytes fold into the running checksum.
            state_d    = START;
            txd_d      = 1'b0;
            bit_cnt_d  = DIV_M1;
            byte_idx_d = byte_idx_q + IDX_W'(1);
            byte_d     = next_byte_c;
            if ((byte_idx_q >= IDX_W'(1)) && (byte_idx_q <= IDX_W'(16))) begin
              csum_d = csum_q + next_byte_c;
            end
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      byte_q     <= '0;
      csum_q     <= '0;
      dat_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      byte_q     <= byte_d;
      csum_q     <= csum_d;
      dat_q      <= dat_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      pkt_done_q <= pkt_done_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign pkt_done = pkt_done_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ad_uart_tx.sv
// Directed bench for ad_uart_tx: decodes the serial frame at bit midpoints and
// compares each byte, timing and status output against hand-built expectations.
module tb_ad_uart_tx;

  localparam int unsigned D   = 4;
  localparam int unsigned PKT = 190 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        snap = 1'b0;
  logic [13:0] ad_dat [8];
  logic [13:0] ref_dat [8];
  logic        txd, busy, pkt_done;
  logic [7:0]  drop_cnt;
  logic [7:0]  rx [19];
  logic [7:0]  exp_b [19];

  int n_checks = 0;
  int n_errors = 0;

  ad_uart_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .snap(snap),
    .ad_dat0(ad_dat[0]), .ad_dat1(ad_dat[1]), .ad_dat2(ad_dat[2]), .ad_dat3(ad_dat[3]),
    .ad_dat4(ad_dat[4]), .ad_dat5(ad_dat[5]), .ad_dat6(ad_dat[6]), .ad_dat7(ad_dat[7]),
    .txd(txd), .busy(busy), .pkt_done(pkt_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic build_exp();
    logic [7:0] sum;
    sum = 8'h00;
    exp_b[0] = 8'hAA;
    exp_b[1] = 8'h55;
    for (int c = 0; c < 8; c++) begin
      exp_b[2 + 2*c] = {2'b00, ref_dat[c][13:8]};
      exp_b[3 + 2*c] = ref_dat[c][7:0];
      sum = sum + exp_b[2 + 2*c] + exp_b[3 + 2*c];
    end
    exp_b[18] = sum;
  endtask

  task automatic latch_ref();
    for (int c = 0; c < 8; c++) ref_dat[c] = ad_dat[c];
    build_exp();
  endtask

  // Called right after the accepting edge (+1); returns at the busy-fall negedge.
  task automatic capture(input string name);
    logic [9:0] bits;
    int busy_bad;
    int done_bad;
    logic first_txd;
    busy_bad = 0;
    done_bad = 0;
    bits = '0;
    first_txd = 1'b1;
    for (int b = 0; b < 19; b++) begin
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < int'(D); c++) begin
          @(negedge clk);
          if (b == 0 && k == 0 && c == 0) first_txd = txd;
          if (busy !== 1'b1) busy_bad++;
          if (pkt_done !== 1'b0) done_bad++;
          if (c == int'(D) / 2) bits[k] = txd;
        end
      end
      check($sformatf("%s_start%0d", name, b), 32'(bits[0]), 32'd0);
      check($sformatf("%s_stop%0d", name, b), 32'(bits[9]), 32'd1);
      rx[b] = bits[8:1];
    end
    check({name, "_start_edge"}, 32'(first_txd), 32'd0);
    check({name, "_busy_len"}, 32'(busy_bad), 32'd0);
    check({name, "_done_early"}, 32'(done_bad), 32'd0);
    @(negedge clk);
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
    check({name, "_pkt_done"}, 32'(pkt_done), 32'd1);
    check({name, "_txd_idle"}, 32'(txd), 32'd1);
  endtask

  task automatic compare(input string name);
    for (int i = 0; i < 19; i++)
      check($sformatf("%s_byte%0d", name, i), 32'(rx[i]), 32'(exp_b[i]));
  endtask

  task automatic pulse_snap_now();
    snap = 1'b1;
    @(posedge clk);
    #1 snap = 1'b0;
  endtask

  task automatic send_snap();
    @(negedge clk);
    pulse_snap_now();
  endtask

  initial begin
    int done_seen;
    for (int c = 0; c < 8; c++) ad_dat[c] = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pkt_done), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // Ascending channel values
    for (int c = 0; c < 8; c++) ad_dat[c] = 14'(c + 1);
    latch_ref();
    send_snap();
    capture("p1");
    compare("p1");
    check("p1_csum_hand", 32'(rx[18]), 32'h24);
    check("p1_b3_hand", 32'(rx[3]), 32'h01);
    @(negedge clk);
    check("p1_done_one_cycle", 32'(pkt_done), 32'd0);
    check("p1_idle_txd", 32'(txd), 32'd1);
    check("p1_drop", 32'(drop_cnt), 32'd0);

    // Full-scale channels
    for (int c = 0; c < 8; c++) ad_dat[c] = 14'h3FFF;
    latch_ref();
    send_snap();
    capture("p2");
    compare("p2");
    check("p2_hi_hand", 32'(rx[2]), 32'h3F);
    check("p2_lo_hand", 32'(rx[3]), 32'hFF);
    check("p2_csum_hand", 32'(rx[18]), 32'hF0);

    // Snap ignored mid-packet
    ad_dat[0] = 14'h1234; ad_dat[1] = 14'h0ABC; ad_dat[2] = 14'h2AAA; ad_dat[3] = 14'h0000;
    ad_dat[4] = 14'h1555; ad_dat[5] = 14'h0100; ad_dat[6] = 14'h00FF; ad_dat[7] = 14'h3F00;
    latch_ref();
    send_snap();
    fork
      capture("p3");
      begin
        repeat (100) @(negedge clk);
        ad_dat[0] = 14'h0777;
        pulse_snap_now();
      end
    join
    compare("p3");
    check("p3_drop", 32'(drop_cnt), 32'd1);

    // Data changes mid-packet, then snap on the busy-fall cycle
    for (int c = 0; c < 8; c++) ad_dat[c] = 14'(16'h0F0F ^ (c * 16'h0321));
    latch_ref();
    send_snap();
    fork
      capture("p4a");
      begin
        repeat (50) @(negedge clk);
        for (int c = 0; c < 8; c++) ad_dat[c] = 14'(16'h2468 + c * 16'h0413);
      end
    join
    compare("p4a");
    pulse_snap_now();
    latch_ref();
    capture("p4b");
    compare("p4b");
    check("p4_drop_unchanged", 32'(drop_cnt), 32'd1);

    // Long snap burst saturates the drop counter
    for (int c = 0; c < 8; c++) ad_dat[c] = 14'(c * 16'h0801 + 16'h0055);
    latch_ref();
    send_snap();
    fork
      capture("p5");
      begin
        repeat (100) @(negedge clk);
        snap = 1'b1;
        repeat (300) @(posedge clk);
        #1 snap = 1'b0;
      end
    join
    compare("p5");
    check("p5_drop_sat", 32'(drop_cnt), 32'd255);

    // Reset in the middle of byte 7's data bits
    send_snap();
    repeat (290) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(pkt_done), 32'd0);
    check("rst_mid_drop", 32'(drop_cnt), 32'd0);
    for (int c = 0; c < 8; c++) ad_dat[c] = 14'(16'h3A5C - c * 16'h0707);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pkt_done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) done_seen++;
    end
    check("rst_hold_quiet", 32'(done_seen), 32'd0);
    latch_ref();
    rst = 1'b1;
    pulse_snap_now();
    capture("p6");
    compare("p6");
    @(negedge clk);
    check("end_idle_txd", 32'(txd), 32'd1);
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
